// File: rtl/hls_mon_pkg.sv
// Shared types and default widths for the HLS ap_ctrl / pipelined-loop monitor.
package hls_mon_pkg;

  localparam int unsigned STATE_W_DEF = 4;
  localparam int unsigned CNT_W_DEF   = 32;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    BUSY      = 2'd1,
    DONE_WAIT = 2'd2
  } mod_state_t;

endpackage : hls_mon_pkg

// File: rtl/sat_counter.sv
// Up/down counter that clamps at all-ones and at zero; simultaneous inc and dec cancel.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         en_i,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] cnt_q, cnt_d;

  // NOTE: default assigned first so no path through always_comb leaves cnt_d unassigned (no latch).
  always_comb begin
    cnt_d = cnt_q;
    if (en_i) begin
      if (inc_i && !dec_i && (cnt_q != '1)) begin
        cnt_d = cnt_q + ONE;
      end else if (dec_i && !inc_i && (cnt_q != '0)) begin
        cnt_d = cnt_q - ONE;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule : sat_counter

// File: rtl/hls_ctrl_loop_monitor.sv
// Passive monitor of an HLS block's ap_ctrl handshake and pipelined loop FSM;
// all status and counters are registered and freeze once finish is seen.
module hls_ctrl_loop_monitor
  import hls_mon_pkg::*;
#(
  parameter int unsigned STATE_W = STATE_W_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               ap_start,
  input  logic               ap_ready,
  input  logic               ap_done,
  input  logic               ap_continue,
  input  logic               finish,
  input  logic [STATE_W-1:0] cur_state,
  input  logic [STATE_W-1:0] iter_start_state,
  input  logic [STATE_W-1:0] iter_end_state,
  input  logic [STATE_W-1:0] quit_state,
  input  logic               iter_start_block,
  input  logic               iter_end_block,
  input  logic               quit_block,
  input  logic               iter_start_enable,
  input  logic               iter_end_enable,
  input  logic               quit_enable,
  input  logic               loop_start,
  input  logic               loop_ready,
  input  logic               loop_done,
  input  logic               loop_continue,
  input  logic               quit_at_end,
  output logic [1:0]         mod_state,
  output logic [CNT_W-1:0]   mod_start_cnt,
  output logic [CNT_W-1:0]   mod_ready_cnt,
  output logic [CNT_W-1:0]   mod_done_cnt,
  output logic [CNT_W-1:0]   mod_busy_cyc,
  output logic               loop_active,
  output logic [CNT_W-1:0]   loop_inv_cnt,
  output logic [CNT_W-1:0]   iter_start_cnt,
  output logic [CNT_W-1:0]   iter_end_cnt,
  output logic [CNT_W-1:0]   stall_cyc,
  output logic [CNT_W-1:0]   inflight,
  output logic               err_done_idle,
  output logic               err_end_empty,
  output logic               frozen
);

  mod_state_t mod_state_q, mod_state_d;
  logic       loop_active_q, loop_active_d;
  logic       err_done_idle_q, err_end_empty_q, frozen_q;

  logic       run;
  logic       start_inc, done_inc, busy_inc, err_idle_set;
  logic       inv_inc;
  logic       ev_s, ev_e, ev_q, ev_end, ev_stall, err_empty_set;

  // loop_ready carries no information beyond the stage qualifiers.
  logic       unused_loop_ready;
  assign unused_loop_ready = loop_ready;

  // The finish cycle itself is already excluded from all accounting.
  assign run = !frozen_q && !finish;

  always_comb begin
    mod_state_d  = mod_state_q;
    start_inc    = 1'b0;
    done_inc     = 1'b0;
    err_idle_set = 1'b0;
    unique case (mod_state_q)
      IDLE: begin
        if (ap_start) begin
          start_inc = 1'b1;
          if (ap_done) begin
            done_inc = 1'b1;
            if (ap_continue) mod_state_d = IDLE;
            else             mod_state_d = DONE_WAIT;
          end else begin
            mod_state_d = BUSY;
          end
        end else if (ap_done) begin
          err_idle_set = 1'b1;
        end
      end
      BUSY: begin
        if (ap_done) begin
          done_inc = 1'b1;
          if (ap_continue) mod_state_d = IDLE;
          else             mod_state_d = DONE_WAIT;
        end
      end
      DONE_WAIT: begin
        if (ap_continue) begin
          if (ap_start) begin
            start_inc   = 1'b1;
            mod_state_d = BUSY;
          end else begin
            mod_state_d = IDLE;
          end
        end
      end
      default: mod_state_d = IDLE;
    endcase
  end

  assign busy_inc = (mod_state_q != IDLE);

  // A done coinciding with a fresh start re-arms the loop instead of closing it.
  always_comb begin
    loop_active_d = loop_active_q;
    inv_inc       = 1'b0;
    if (!loop_active_q) begin
      if (loop_start) begin
        loop_active_d = 1'b1;
        inv_inc       = 1'b1;
      end
    end else if (loop_done) begin
      if (loop_start) begin
        inv_inc = 1'b1;
      end else if (loop_continue) begin
        loop_active_d = 1'b0;
      end
    end
  end

  assign ev_s = (cur_state == iter_start_state) && iter_start_enable && !iter_start_block;
  assign ev_e = (cur_state == iter_end_state) && iter_end_enable && !iter_end_block;
  assign ev_q = quit_at_end && (cur_state == quit_state) && quit_enable && !quit_block;

  // The quit stage is the end stage when quit_at_end is set, so it folds into one end event.
  assign ev_end        = ev_e || ev_q;
  assign err_empty_set = ev_end && !ev_s && (inflight == '0);
  assign ev_stall      = loop_active_q && (cur_state == iter_start_state) &&
                         iter_start_enable && iter_start_block;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mod_state_q     <= IDLE;
      loop_active_q   <= 1'b0;
      err_done_idle_q <= 1'b0;
      err_end_empty_q <= 1'b0;
      frozen_q        <= 1'b0;
    end else begin
      frozen_q <= frozen_q || finish;
      if (run) begin
        mod_state_q     <= mod_state_d;
        loop_active_q   <= loop_active_d;
        err_done_idle_q <= err_done_idle_q || err_idle_set;
        err_end_empty_q <= err_end_empty_q || err_empty_set;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_start_cnt (
    .clock(clock), .reset(reset), .en_i(run), .inc_i(start_inc), .dec_i(1'b0), .cnt_o(mod_start_cnt)
  );
  sat_counter #(.W(CNT_W)) u_ready_cnt (
    .clock(clock), .reset(reset), .en_i(run), .inc_i(ap_ready), .dec_i(1'b0), .cnt_o(mod_ready_cnt)
  );
  sat_counter #(.W(CNT_W)) u_done_cnt (
    .clock(clock), .reset(reset), .en_i(run), .inc_i(done_inc), .dec_i(1'b0), .cnt_o(mod_done_cnt)
  );
  sat_counter #(.W(CNT_W)) u_busy_cyc (
    .clock(clock), .reset(reset), .en_i(run), .inc_i(busy_inc), .dec_i(1'b0), .cnt_o(mod_busy_cyc)
  );
  sat_counter #(.W(CNT_W)) u_loop_inv_cnt (
    .clock(clock), .reset(reset), .en_i(run), .inc_i(inv_inc), .dec_i(1'b0), .cnt_o(loop_inv_cnt)
  );
  sat_counter #(.W(CNT_W)) u_iter_start_cnt (
    .clock(clock), .reset(reset), .en_i(run), .inc_i(ev_s), .dec_i(1'b0), .cnt_o(iter_start_cnt)
  );
  sat_counter #(.W(CNT_W)) u_iter_end_cnt (
    .clock(clock), .reset(reset), .en_i(run), .inc_i(ev_end), .dec_i(1'b0), .cnt_o(iter_end_cnt)
  );
  sat_counter #(.W(CNT_W)) u_stall_cyc (
    .clock(clock), .reset(reset), .en_i(run), .inc_i(ev_stall), .dec_i(1'b0), .cnt_o(stall_cyc)
  );
  sat_counter #(.W(CNT_W)) u_inflight (
    .clock(clock), .reset(reset), .en_i(run), .inc_i(ev_s), .dec_i(ev_end), .cnt_o(inflight)
  );

  assign mod_state     = mod_state_q;
  assign loop_active   = loop_active_q;
  assign err_done_idle = err_done_idle_q;
  assign err_end_empty = err_end_empty_q;
  assign frozen        = frozen_q;

endmodule : hls_ctrl_loop_monitor

// File: tb/tb_hls_ctrl_loop_monitor.sv
// Directed bench for hls_ctrl_loop_monitor with narrow counters so saturation is reachable.
module tb_hls_ctrl_loop_monitor;

  localparam int SW = 4;
  localparam int CW = 4;

  logic          clock, reset;
  logic          ap_start, ap_ready, ap_done, ap_continue, finish;
  logic [SW-1:0] cur_state, iter_start_state, iter_end_state, quit_state;
  logic          iter_start_block, iter_end_block, quit_block;
  logic          iter_start_enable, iter_end_enable, quit_enable;
  logic          loop_start, loop_ready, loop_done, loop_continue, quit_at_end;
  logic [1:0]    mod_state;
  logic [CW-1:0] mod_start_cnt, mod_ready_cnt, mod_done_cnt, mod_busy_cyc;
  logic          loop_active;
  logic [CW-1:0] loop_inv_cnt, iter_start_cnt, iter_end_cnt, stall_cyc, inflight;
  logic          err_done_idle, err_end_empty, frozen;

  int n_vec  = 0;
  int n_miss = 0;

  hls_ctrl_loop_monitor #(.STATE_W(SW), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset),
    .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done), .ap_continue(ap_continue),
    .finish(finish), .cur_state(cur_state),
    .iter_start_state(iter_start_state), .iter_end_state(iter_end_state), .quit_state(quit_state),
    .iter_start_block(iter_start_block), .iter_end_block(iter_end_block), .quit_block(quit_block),
    .iter_start_enable(iter_start_enable), .iter_end_enable(iter_end_enable), .quit_enable(quit_enable),
    .loop_start(loop_start), .loop_ready(loop_ready), .loop_done(loop_done),
    .loop_continue(loop_continue), .quit_at_end(quit_at_end),
    .mod_state(mod_state), .mod_start_cnt(mod_start_cnt), .mod_ready_cnt(mod_ready_cnt),
    .mod_done_cnt(mod_done_cnt), .mod_busy_cyc(mod_busy_cyc), .loop_active(loop_active),
    .loop_inv_cnt(loop_inv_cnt), .iter_start_cnt(iter_start_cnt), .iter_end_cnt(iter_end_cnt),
    .stall_cyc(stall_cyc), .inflight(inflight), .err_done_idle(err_done_idle),
    .err_end_empty(err_end_empty), .frozen(frozen)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Outputs are sampled and inputs changed 1 ns after each rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic clear_loop_inputs();
    cur_state = '0; iter_start_enable = 1'b0; iter_end_enable = 1'b0; quit_enable = 1'b0;
    iter_start_block = 1'b0; iter_end_block = 1'b0; quit_block = 1'b0; quit_at_end = 1'b0;
    loop_start = 1'b0; loop_done = 1'b0; loop_continue = 1'b0; loop_ready = 1'b0;
  endtask

  initial begin
    int peak;
    reset = 1'b1;
    ap_start = 1'b0; ap_ready = 1'b0; ap_done = 1'b0; ap_continue = 1'b1; finish = 1'b0;
    iter_start_state = 4'd3; iter_end_state = 4'd3; quit_state = 4'd3;
    clear_loop_inputs();
    tick(); tick();
    reset = 1'b0;
    check("rst_state",    32'(mod_state), 0);
    check("rst_active",   32'(loop_active), 0);
    check("rst_inflight", 32'(inflight), 0);
    check("rst_frozen",   32'(frozen), 0);

    // Reset in the middle of BUSY with three starts recorded.
    for (int i = 0; i < 3; i++) begin
      ap_start = 1'b1; tick(); ap_start = 1'b0;
      if (i < 2) begin
        ap_done = 1'b1; tick(); ap_done = 1'b0;
      end
    end
    check("pre_rst_start", 32'(mod_start_cnt), 3);
    check("pre_rst_state", 32'(mod_state), 1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_state", 32'(mod_state), 0);
    check("async_rst_start", 32'(mod_start_cnt), 0);
    check("async_rst_busy",  32'(mod_busy_cyc), 0);
    tick();
    reset = 1'b0;
    check("post_rst_done", 32'(mod_done_cnt), 0);

    // Single invocation, done five cycles after start.
    ap_start = 1'b1; tick(); ap_start = 1'b0;
    check("busy_state", 32'(mod_state), 1);
    ap_ready = 1'b1; tick(); ap_ready = 1'b0;
    tick(); tick(); tick();
    ap_done = 1'b1; tick(); ap_done = 1'b0;
    check("inv_start", 32'(mod_start_cnt), 1);
    check("inv_done",  32'(mod_done_cnt), 1);
    check("inv_busy",  32'(mod_busy_cyc), 5);
    check("inv_ready", 32'(mod_ready_cnt), 1);
    check("inv_state", 32'(mod_state), 0);

    // Back-pressured completion, done-in-idle error, single-cycle block.
    do_reset();
    ap_start = 1'b1; tick(); ap_start = 1'b0;
    ap_continue = 1'b0; ap_done = 1'b1; tick(); ap_done = 1'b0;
    check("dw_state0", 32'(mod_state), 2);
    tick();
    check("dw_state1", 32'(mod_state), 2);
    tick();
    check("dw_state2", 32'(mod_state), 2);
    ap_continue = 1'b1; tick();
    check("dw_idle", 32'(mod_state), 0);
    check("dw_done", 32'(mod_done_cnt), 1);
    check("dw_busy", 32'(mod_busy_cyc), 4);
    ap_done = 1'b1; tick(); ap_done = 1'b0;
    check("err_idle",      32'(err_done_idle), 1);
    check("err_idle_done", 32'(mod_done_cnt), 1);
    ap_start = 1'b1; ap_done = 1'b1; ap_continue = 1'b0; tick();
    check("sc_state", 32'(mod_state), 2);
    check("sc_start", 32'(mod_start_cnt), 2);
    check("sc_done",  32'(mod_done_cnt), 2);
    ap_done = 1'b0; ap_continue = 1'b1; tick(); ap_start = 1'b0;
    check("dw_restart_state", 32'(mod_state), 1);
    check("dw_restart_start", 32'(mod_start_cnt), 3);
    ap_done = 1'b1; tick(); ap_done = 1'b0;
    check("dw_restart_done", 32'(mod_done_cnt), 3);

    // Pipelined loop: II = 2, 10 iterations, 8 stages (end 7 cycles after start).
    do_reset();
    loop_start = 1'b1; tick(); loop_start = 1'b0;
    check("pipe_active", 32'(loop_active), 1);
    cur_state = 4'd3;
    peak = 0;
    for (int c = 0; c < 26; c++) begin
      iter_start_enable = (c % 2 == 0) && (c < 20);
      iter_end_enable   = (c >= 7) && ((c - 7) % 2 == 0) && (c < 27);
      tick();
      if (int'(inflight) > peak) peak = int'(inflight);
    end
    iter_start_enable = 1'b0; iter_end_enable = 1'b0;
    check("pipe_starts", 32'(iter_start_cnt), 10);
    check("pipe_ends",   32'(iter_end_cnt), 10);
    check("pipe_peak",   32'(peak), 4);
    check("pipe_final",  32'(inflight), 0);
    check("pipe_inv",    32'(loop_inv_cnt), 1);
    check("pipe_noerr",  32'(err_end_empty), 0);
    loop_done = 1'b1; loop_continue = 1'b1; tick();
    loop_done = 1'b0; loop_continue = 1'b0;
    check("pipe_inactive", 32'(loop_active), 0);

    // Stalls, coincident S/E, quit folded into end, end on empty pipe.
    do_reset();
    clear_loop_inputs();
    loop_start = 1'b1; tick(); loop_start = 1'b0;
    cur_state = 4'd3; iter_start_enable = 1'b1; iter_start_block = 1'b1;
    tick(); tick(); tick();
    check("stall_cyc",    32'(stall_cyc), 3);
    check("stall_nostart", 32'(iter_start_cnt), 0);
    iter_start_block = 1'b0; tick();
    check("s_inflight", 32'(inflight), 1);
    iter_end_enable = 1'b1; tick();
    check("se_inflight", 32'(inflight), 1);
    check("se_starts",   32'(iter_start_cnt), 2);
    check("se_ends",     32'(iter_end_cnt), 1);
    iter_start_enable = 1'b0; quit_at_end = 1'b1; quit_enable = 1'b1; tick();
    check("qe_ends",     32'(iter_end_cnt), 2);
    check("qe_inflight", 32'(inflight), 0);
    quit_at_end = 1'b0; quit_enable = 1'b0; tick();
    check("empty_err",      32'(err_end_empty), 1);
    check("empty_inflight", 32'(inflight), 0);
    check("empty_ends",     32'(iter_end_cnt), 3);
    iter_end_enable = 1'b0;
    loop_done = 1'b1; loop_start = 1'b1; tick();
    check("reinv_cnt",    32'(loop_inv_cnt), 2);
    check("reinv_active", 32'(loop_active), 1);
    loop_start = 1'b0; loop_continue = 1'b1; tick();
    loop_done = 1'b0; loop_continue = 1'b0;
    check("loop_closed", 32'(loop_active), 0);
    iter_start_enable = 1'b1; iter_start_block = 1'b1; tick();
    iter_start_enable = 1'b0; iter_start_block = 1'b0;
    check("stall_inactive", 32'(stall_cyc), 3);

    // Saturation after 20 invocations, then freeze.
    do_reset();
    clear_loop_inputs();
    for (int i = 0; i < 20; i++) begin
      ap_start = 1'b1; tick(); ap_start = 1'b0;
      ap_done = 1'b1; tick(); ap_done = 1'b0;
    end
    check("sat_start", 32'(mod_start_cnt), 15);
    check("sat_done",  32'(mod_done_cnt), 15);
    check("sat_busy",  32'(mod_busy_cyc), 15);
    finish = 1'b1; ap_start = 1'b1; ap_ready = 1'b1;
    cur_state = 4'd3; iter_start_enable = 1'b1;
    tick();
    finish = 1'b0; ap_start = 1'b0; iter_start_enable = 1'b0;
    check("frz_flag",  32'(frozen), 1);
    check("frz_state", 32'(mod_state), 0);
    check("frz_ready", 32'(mod_ready_cnt), 0);
    check("frz_iter",  32'(iter_start_cnt), 0);
    for (int i = 0; i < 2; i++) begin
      ap_start = 1'b1; tick(); ap_start = 1'b0;
      ap_done = 1'b1; tick(); ap_done = 1'b0;
    end
    ap_ready = 1'b0;
    check("frz_start2", 32'(mod_start_cnt), 15);
    check("frz_ready2", 32'(mod_ready_cnt), 0);
    check("frz_state2", 32'(mod_state), 0);
    check("frz_still",  32'(frozen), 1);
    do_reset();
    check("frz_cleared", 32'(frozen), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule : tb_hls_ctrl_loop_monitor

// File: doc/hls_ctrl_loop_monitor.md
Name: hls_ctrl_loop_monitor

Overview:
- Synthesizable run-time monitor for one HLS-generated block.
- Observes the block's ap_ctrl handshake (ap_start/ap_ready/ap_done/ap_continue) and its pipelined loop FSM (state, per-stage enable, block/stall signals).
- Produces registered status and performance counters: invocations, completions, busy cycles, loop iterations, in-flight iterations and stall cycles.
- Sits beside the DUT in simulation or debug builds; purely passive (no outputs drive the observed block).

Parameters:
- STATE_W, 4, width of the loop FSM state vector and of the state-code inputs.
- CNT_W, 32, width of every counter output.

Ports:
- clock  in  1  single system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- ap_start  in  1  module start request.
- ap_ready  in  1  module accepted inputs.
- ap_done  in  1  module completed.
- ap_continue  in  1  downstream accepts completion.
- finish  in  1  end-of-test; freezes monitor.
- cur_state  in  STATE_W  loop FSM current state.
- iter_start_state / iter_end_state / quit_state  in  STATE_W  state codes.
- iter_start_block / iter_end_block / quit_block  in  1  stage subdone-block (1 = stalled).
- iter_start_enable / iter_end_enable / quit_enable  in  1  pipeline stage-valid flags.
- loop_start / loop_ready / loop_done / loop_continue  in  1  loop-level handshake.
- quit_at_end  in  1  1 = loop exits via the end stage.
- mod_state  out  2  0 IDLE, 1 BUSY, 2 DONE_WAIT.
- mod_start_cnt / mod_ready_cnt / mod_done_cnt / mod_busy_cyc  out  CNT_W  module counters.
- loop_active  out  1  loop invocation in progress.
- loop_inv_cnt / iter_start_cnt / iter_end_cnt / stall_cyc  out  CNT_W  loop counters.
- inflight  out  CNT_W  iterations started but not ended.
- err_done_idle  out  1  sticky: ap_done seen in IDLE without ap_start.
- err_end_empty  out  1  sticky: iteration end with inflight = 0.
- frozen  out  1  sticky: finish observed.

Behaviour:
- Reset: all outputs, counters and states are 0 (mod_state = IDLE, loop_active = 0). Reset takes effect asynchronously and can occur mid-operation; it discards everything.
- All outputs are registered. An event sampled at rising edge N is visible after edge N.
- Module FSM:
  - IDLE & ap_start → BUSY, mod_start_cnt++.
  - IDLE & ap_start & ap_done in the same cycle (single-cycle block): start and done both count. Next state is IDLE if ap_continue = 1, otherwise DONE_WAIT.
  - BUSY & ap_done & ap_continue → IDLE, done++.
  - BUSY & ap_done & !ap_continue → DONE_WAIT, done++.
  - DONE_WAIT & ap_continue → IDLE; if ap_start is also high, go to BUSY and start++.
  - IDLE & ap_done without ap_start: sets err_done_idle; no count.
  - ap_ready counts in any state.
  - mod_busy_cyc increments every cycle mod_state != IDLE.
- Loop events (combinational qualifiers):
  - S = (cur_state == iter_start_state) & iter_start_enable & !iter_start_block.
  - E = (cur_state == iter_end_state) & iter_end_enable & !iter_end_block.
  - Q = quit_at_end & (cur_state == quit_state) & quit_enable & !quit_block.
- Loop FSM:
  - !loop_active & loop_start → active, loop_inv_cnt++.
  - active & loop_done & loop_continue → inactive.
  - loop_done & loop_start in the same cycle: stays active, counts a new invocation.
- Loop counters:
  - S → iter_start_cnt++.
  - E → iter_end_cnt++.
  - inflight: +1 on S, −1 on E, unchanged if both occur.
  - E with inflight = 0 and no S sets err_end_empty; inflight stays 0.
  - Q is counted as E when it coincides with E; it is never double-counted.
- Stall: stall_cyc++ each cycle loop_active & (cur_state == iter_start_state) & iter_start_enable & iter_start_block.
- loop_ready is ignored beyond S/E accounting.
- Counters saturate at all-ones; they never wrap.
- Freeze: finish high at edge N sets frozen. From that edge onward no counter, state or error flag updates, and events in cycle N itself are not counted. Only reset clears frozen.

Decomposition:
- Package hls_mon_pkg:
  - mod_state_t enum (IDLE/BUSY/DONE_WAIT).
  - Default width constants.
- Sub-module sat_counter (CNT_W; inc, dec, en inputs; saturating at all-ones and at 0), instantiated per counter and used for inflight.

Test Plan:
- Reset mid-BUSY with mod_start_cnt = 3 → all outputs 0, mod_state = 0 on the next edge.
- ap_start 1 cycle; ap_done 5 cycles later with ap_continue = 1 → start_cnt = 1, done_cnt = 1, busy_cyc = 5, mod_state back to 0.
- ap_done with ap_continue = 0 for 3 cycles, then continue = 1 → mod_state = 2 for 3 cycles, then 0; done_cnt = 1.
- Pipeline with II = 2, 10 iterations, latency 8 stages → iter_start_cnt = 10, iter_end_cnt = 10, inflight peaks at 4 and ends at 0, loop_inv_cnt = 1.
- iter_start_block held 3 cycles in the start state with enable = 1 → stall_cyc = 3. Simultaneous S and E → inflight unchanged.
- Counter preset near all-ones via a long run, or CNT_W = 4 with 20 starts → mod_start_cnt = 15. finish asserted, then 2 more starts → counts unchanged and frozen = 1.
